// File: rtl/user_event_arbiter.sv
// rtl/user_event_arbiter.sv - round-robin merge of game-control event sources into a show-ahead event FIFO
// Optional feature macro: USER_EVENT_ARB_NEWGAME_FLUSH_EN (an accepted EV_NEW_GAME flushes stale queued moves)
module user_event_arbiter #(
  parameter int SRC_CNT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SRC_CNT-1:0]              src_valid_i,
  input  logic [SRC_CNT*3-1:0]            src_event_i,
  output logic [SRC_CNT-1:0]              src_ack_o,
  output logic [2:0]                      user_event_o,
  output logic                            user_event_ready_o,
  input  logic                            user_event_rd_req_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] occupancy_o,
  output logic [7:0]                      drop_flush_cnt_o
);
  localparam int RR_W  = (SRC_CNT > 1) ? $clog2(SRC_CNT) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  logic [RR_W-1:0]  rr_ptr;
  logic [RR_W-1:0]  gnt_idx;
  logic [RR_W-1:0]  rr_next;
  logic             gnt_found;
  logic [2:0]       gnt_event;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [2:0]       mem [FIFO_DEPTH];
  logic             full;
  logic             pop;
  logic             push;
  logic             flush_req;
  logic             flush;

  // Pick the first requesting source at or after rr_ptr; scanning backwards lets the nearest one win.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = SRC_CNT - 1; k >= 0; k--) begin
      if (1'(src_valid_i >> ((int'(rr_ptr) + k) % SRC_CNT))) begin
        gnt_found = 1'b1;
        gnt_idx   = RR_W'((int'(rr_ptr) + k) % SRC_CNT);
      end
    end
  end

  assign gnt_event = 3'(src_event_i >> (3 * int'(gnt_idx)));
  assign rr_next   = RR_W'((int'(gnt_idx) + 1) % SRC_CNT);

  assign full = (occ == OCC_W'(FIFO_DEPTH));
  // A read request against an empty FIFO is ignored so occupancy cannot underflow.
  assign pop  = user_event_rd_req_i && (occ != '0);

`ifdef USER_EVENT_ARB_NEWGAME_FLUSH_EN
  localparam logic [2:0] EV_NEW_GAME = 3'd5;
  assign flush_req = gnt_found && (gnt_event == EV_NEW_GAME);
`else
  assign flush_req = 1'b0;
`endif

  // A full FIFO still accepts when the head leaves this cycle, or when the event flushes everything.
  assign push  = gnt_found && !rst && (!full || pop || flush_req);
  assign flush = push && flush_req;

  assign src_ack_o          = push ? (SRC_CNT'(1) << gnt_idx) : '0;
  assign user_event_ready_o = (occ != '0);
  assign user_event_o       = user_event_ready_o ? mem[rd_ptr] : 3'd0;
  assign occupancy_o        = occ;

  // Arbitration and FIFO pointer/occupancy state; a flush leaves only the event written this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        rr_ptr <= rr_next;
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (flush) begin
        rd_ptr <= wr_ptr;
        occ    <= OCC_W'(1);
      end else begin
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop) occ <= occ + OCC_W'(1);
        else if (!push && pop) occ <= occ - OCC_W'(1);
      end
    end
  end

  // Event storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= gnt_event;
  end

`ifdef USER_EVENT_ARB_NEWGAME_FLUSH_EN
  logic [OCC_W-1:0] discard;
  logic [8:0]       drop_sum;
  logic [7:0]       drop_cnt;

  // A head popped in the flush cycle is delivered, so it does not count as discarded.
  assign discard  = occ - (pop ? OCC_W'(1) : OCC_W'(0));
  assign drop_sum = 9'(drop_cnt) + 9'(discard);

  // Saturating tally of entries thrown away by flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt <= '0;
    else if (flush) drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  assign drop_flush_cnt_o = drop_cnt;
`else
  assign drop_flush_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_user_event_arbiter.sv
// tb/tb_user_event_arbiter.sv - self-checking bench for user_event_arbiter
module tb_user_event_arbiter;
  localparam int SRC_CNT = 2;
  localparam int DEPTH   = 4;
  localparam logic [2:0] EV_NONE = 3'd0, EV_LEFT = 3'd1, EV_RIGHT = 3'd2, EV_DOWN = 3'd3,
                         EV_ROTATE = 3'd4, EV_NEW_GAME = 3'd5;
`ifdef USER_EVENT_ARB_NEWGAME_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] src_valid_i = '0;
  logic [5:0] src_event_i = '0;
  logic [1:0] src_ack_o;
  logic [2:0] user_event_o;
  logic       user_event_ready_o;
  logic       user_event_rd_req_i = 1'b0;
  logic [2:0] occupancy_o;
  logic [7:0] drop_flush_cnt_o;

  user_event_arbiter #(.SRC_CNT(SRC_CNT), .FIFO_DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .src_valid_i         (src_valid_i),
    .src_event_i         (src_event_i),
    .src_ack_o           (src_ack_o),
    .user_event_o        (user_event_o),
    .user_event_ready_o  (user_event_ready_o),
    .user_event_rd_req_i (user_event_rd_req_i),
    .occupancy_o         (occupancy_o),
    .drop_flush_cnt_o    (drop_flush_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: a queue of events, a scan start index and a drop tally
  logic [2:0] mq[$];
  int         m_rr = 0;
  int         m_drop = 0;
  int         g_sel;
  bit         m_pop;
  bit         m_flush;
  logic [2:0] m_ev;

  logic [1:0] obs_ack;
  logic       pre_rdy;
  logic [2:0] pre_head;

  typedef struct {
    logic [1:0] v;
    logic [5:0] ev;
    logic       rd;
    logic [1:0] ack;
    int         occ;
    logic       rdy;
    logic [2:0] head;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_eval(input logic [1:0] v, input logic [5:0] ev, input logic rd);
    m_pop   = rd && (mq.size() > 0);
    g_sel   = -1;
    m_flush = 1'b0;
    m_ev    = EV_NONE;
    for (int k = 0; k < SRC_CNT; k++) begin
      int i;
      i = (m_rr + k) % SRC_CNT;
      if (g_sel < 0 && v[i]) g_sel = i;
    end
    if (g_sel >= 0) begin
      m_ev    = ev[3*g_sel +: 3];
      m_flush = FLUSH && (m_ev == EV_NEW_GAME);
      if (!(mq.size() < DEPTH || m_pop || m_flush)) begin
        g_sel   = -1;
        m_flush = 1'b0;
      end
    end
  endtask

  task automatic model_commit();
    int n;
    if (m_pop) void'(mq.pop_front());
    if (g_sel >= 0) begin
      if (m_flush) begin
        n = m_drop + mq.size();
        m_drop = (n > 255) ? 255 : n;
        mq.delete();
      end
      mq.push_back(m_ev);
      m_rr = (g_sel + 1) % SRC_CNT;
    end
  endtask

  // one clock: drive at negedge, check ack mid-cycle, check registered state after the edge
  task automatic step(input logic [1:0] v, input logic [5:0] ev, input logic rd);
    src_valid_i = v;
    src_event_i = ev;
    user_event_rd_req_i = rd;
    #2;
    obs_ack  = src_ack_o;
    pre_rdy  = user_event_ready_o;
    pre_head = user_event_o;
    model_eval(v, ev, rd);
    chk("ack", int'(src_ack_o), (g_sel >= 0) ? (1 << g_sel) : 0);
    @(posedge clk);
    #1;
    model_commit();
    chk("occupancy", int'(occupancy_o), mq.size());
    chk("ready", int'(user_event_ready_o), (mq.size() > 0) ? 1 : 0);
    chk("head", int'(user_event_o), (mq.size() > 0) ? int'(mq[0]) : 0);
    chk("drop_cnt", int'(drop_flush_cnt_o), m_drop);
    chk("occ_bound", (occupancy_o <= DEPTH) ? 1 : 0, 1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    src_valid_i = '0;
    src_event_i = '0;
    user_event_rd_req_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_ack", int'(src_ack_o), 0);
    chk("rst_ready", int'(user_event_ready_o), 0);
    chk("rst_occ", int'(occupancy_o), 0);
    chk("rst_head", int'(user_event_o), 0);
    chk("rst_drop", int'(drop_flush_cnt_o), 0);
    mq.delete();
    m_rr = 0;
    m_drop = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [2:0] got[$];
  logic [2:0] e;
  int         n_sent;
  bit         pend[SRC_CNT];
  logic [2:0] pev[SRC_CNT];
  logic [1:0] rv;
  logic [5:0] rev;

  initial begin
    // basic path, round-robin fill to full, full with simultaneous pop, drain, pop on empty
    tbl[0]  = '{2'b01, {EV_NONE, EV_LEFT},     1'b0, 2'b01, 1, 1'b1, EV_LEFT};
    tbl[1]  = '{2'b00, {EV_NONE, EV_NONE},     1'b1, 2'b00, 0, 1'b0, EV_NONE};
    tbl[2]  = '{2'b11, {EV_ROTATE, EV_DOWN},   1'b0, 2'b10, 1, 1'b1, EV_ROTATE};
    tbl[3]  = '{2'b11, {EV_ROTATE, EV_DOWN},   1'b0, 2'b01, 2, 1'b1, EV_ROTATE};
    tbl[4]  = '{2'b11, {EV_ROTATE, EV_DOWN},   1'b0, 2'b10, 3, 1'b1, EV_ROTATE};
    tbl[5]  = '{2'b11, {EV_ROTATE, EV_DOWN},   1'b0, 2'b01, 4, 1'b1, EV_ROTATE};
    tbl[6]  = '{2'b11, {EV_ROTATE, EV_DOWN},   1'b0, 2'b00, 4, 1'b1, EV_ROTATE};
    tbl[7]  = '{2'b11, {EV_ROTATE, EV_DOWN},   1'b0, 2'b00, 4, 1'b1, EV_ROTATE};
    tbl[8]  = '{2'b10, {EV_RIGHT, EV_NONE},    1'b1, 2'b10, 4, 1'b1, EV_DOWN};
    tbl[9]  = '{2'b00, {EV_NONE, EV_NONE},     1'b1, 2'b00, 3, 1'b1, EV_ROTATE};
    tbl[10] = '{2'b00, {EV_NONE, EV_NONE},     1'b1, 2'b00, 2, 1'b1, EV_DOWN};
    tbl[11] = '{2'b00, {EV_NONE, EV_NONE},     1'b1, 2'b00, 1, 1'b1, EV_RIGHT};
    tbl[12] = '{2'b00, {EV_NONE, EV_NONE},     1'b1, 2'b00, 0, 1'b0, EV_NONE};
    tbl[13] = '{2'b00, {EV_NONE, EV_NONE},     1'b1, 2'b00, 0, 1'b0, EV_NONE};

    #1;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].v, tbl[i].ev, tbl[i].rd);
      chk($sformatf("tbl%0d_ack", i), int'(obs_ack), int'(tbl[i].ack));
      chk($sformatf("tbl%0d_occ", i), int'(occupancy_o), tbl[i].occ);
      chk($sformatf("tbl%0d_ready", i), int'(user_event_ready_o), int'(tbl[i].rdy));
      chk($sformatf("tbl%0d_head", i), int'(user_event_o), int'(tbl[i].head));
    end

    // new-game with three queued moves
    do_reset();
    repeat (3) step(2'b01, {EV_NONE, EV_DOWN}, 1'b0);
    step(2'b01, {EV_NONE, EV_NEW_GAME}, 1'b0);
    chk("flush_ack", int'(obs_ack), 1);
`ifdef USER_EVENT_ARB_NEWGAME_FLUSH_EN
    chk("flush_occ", int'(occupancy_o), 1);
    chk("flush_head", int'(user_event_o), int'(EV_NEW_GAME));
    chk("flush_drop", int'(drop_flush_cnt_o), 3);
`else
    chk("noflush_occ", int'(occupancy_o), 4);
    chk("noflush_drop", int'(drop_flush_cnt_o), 0);
    repeat (3) step(2'b00, 6'd0, 1'b1);
    chk("noflush_last", int'(user_event_o), int'(EV_NEW_GAME));
    chk("noflush_last_occ", int'(occupancy_o), 1);
`endif

    // asynchronous reset with two entries queued and the scan pointer at src1
    do_reset();
    step(2'b10, {EV_LEFT, EV_NONE}, 1'b0);
    step(2'b01, {EV_NONE, EV_RIGHT}, 1'b0);
    chk("pre_rst_occ", int'(occupancy_o), 2);
    src_valid_i = 2'b11;
    src_event_i = {EV_ROTATE, EV_DOWN};
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_ready", int'(user_event_ready_o), 0);
    chk("async_rst_occ", int'(occupancy_o), 0);
    chk("async_rst_ack", int'(src_ack_o), 0);
    mq.delete();
    m_rr = 0;
    m_drop = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(2'b11, {EV_ROTATE, EV_DOWN}, 1'b0);
    chk("rst_rearb_both", int'(obs_ack), 1);
    do_reset();
    step(2'b10, {EV_ROTATE, EV_NONE}, 1'b0);
    chk("rst_rearb_src1", int'(obs_ack), 2);

    // ten alternating events through depth 4 with random pop gaps
    do_reset();
    got.delete();
    n_sent = 0;
    for (int cyc = 0; cyc < 300 && (n_sent < 10 || got.size() < 10); cyc++) begin
      e = (n_sent % 2 == 0) ? EV_LEFT : EV_RIGHT;
      step((n_sent < 10) ? 2'b01 : 2'b00, {EV_NONE, e}, ($urandom_range(0, 2) == 0));
      if (obs_ack[0]) n_sent++;
      if (user_event_rd_req_i && pre_rdy) got.push_back(pre_head);
    end
    chk("wrap_sent", n_sent, 10);
    chk("wrap_got", got.size(), 10);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("wrap_seq%0d", i), int'(got[i]), (i % 2 == 0) ? int'(EV_LEFT) : int'(EV_RIGHT));

    // randomized sources that hold each event until acknowledged
    do_reset();
    for (int s = 0; s < SRC_CNT; s++) begin
      pend[s] = 1'b0;
      pev[s] = EV_NONE;
    end
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int s = 0; s < SRC_CNT; s++) begin
        if (!pend[s] && $urandom_range(0, 1) == 1) begin
          pend[s] = 1'b1;
          pev[s] = 3'($urandom_range(1, 5));
        end
      end
      rv  = {pend[1], pend[0]};
      rev = {pev[1], pev[0]};
      step(rv, rev, ($urandom_range(0, 2) == 0));
      for (int s = 0; s < SRC_CNT; s++)
        if (obs_ack[s]) pend[s] = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/user_event_arbiter.md
# user_event_arbiter

Merges game-control events from several independent input sources (PS/2 keyboard decoder, board push-buttons, future remote/UART input) into the single show-ahead event channel consumed by `main_game_logic`. It uses round-robin arbitration among requesting sources and a small FIFO to buffer events. A new-game request can optionally flush stale queued moves. It sits between the per-source input decoders and the game FSM's `user_event_i` / `user_event_ready_i` / `user_event_rd_req_o` port group.

## Interface
- `SRC_CNT`, default 2: number of event sources (1..8).
- `FIFO_DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `src_valid_i` in `SRC_CNT`: source *n* has an event pending; held until acked.
- `src_event_i` in `SRC_CNT*3`: event code of source *n* at bits [3n+2:3n], `EV_*` encoding from `defs.vh`; stable while valid.
- `src_ack_o` out `SRC_CNT`: one-hot, at most one bit set; event of source *n* accepted on this clock edge.
- `user_event_o` out 3: FIFO head event code.
- `user_event_ready_o` out 1: FIFO non-empty; `user_event_o` is valid.
- `user_event_rd_req_i` in 1: pop the head; ignored while ready is low.
- `occupancy_o` out `$clog2(FIFO_DEPTH+1)`: current entry count.
- `drop_flush_cnt_o` out 8: saturating count of entries discarded by flush. Present only with the `_EN` macro; otherwise tied to 0.

## Operation
- **Round-robin pointer `rr_ptr`** (0..`SRC_CNT`-1):
  - The grant goes to the first source with `src_valid_i` set, scanning `rr_ptr`, `rr_ptr`+1, … modulo `SRC_CNT`.
  - On a grant, `rr_ptr` ← granted index + 1, wrapping to 0 after `SRC_CNT`-1.
  - With no grant, `rr_ptr` holds.
- **Accept condition:** a grant is issued only if one of these holds:
  - `occupancy_o` < `FIFO_DEPTH`;
  - the FIFO is full and a pop happens in the same cycle (simultaneous push and pop is legal);
  - flush case, see Configuration.
- **`src_ack_o`** is combinational from valid, `rr_ptr` and occupancy. The source drops valid or presents its next event after the acked edge.
- **Push** writes the granted event at `wr_ptr`, and `wr_ptr` increments. **Pop** increments `rd_ptr`. Both pointers wrap modulo `FIFO_DEPTH`.
- **Occupancy:** +1 on push only, −1 on pop only, unchanged on push and pop together.
- **Event ordering:** events from one source are delivered in acceptance order. No ordering is guaranteed across sources beyond round-robin.
- **Event codes** pass through unmodified; the block does not decode them except for `EV_NEW_GAME` in the flush feature.
- **Requester state:** no internal FSM beyond the pointers. Each requester is conceptually IDLE (valid low) → PENDING (valid high, not granted) → ACKED (ack high for one cycle) → IDLE or PENDING.

## Timing
- **Reset values:** `src_ack_o`=0, `user_event_ready_o`=0, `user_event_o`=0, `occupancy_o`=0, `rr_ptr`=0, `wr_ptr`=`rd_ptr`=0, `drop_flush_cnt_o`=0.
- **Latency:** an event acked at edge N appears at the head with ready=1 after edge N when the FIFO was empty. Latency is 1 cycle; there is no bypass.
- **Pop:** `user_event_rd_req_i` high with ready high at edge N exposes the next entry, or drops ready, after edge N.
- **Full with no pop:** all acks stay 0 and sources wait; nothing is dropped.
- **Empty with `user_event_rd_req_i` high:** no effect. Occupancy must not underflow.
- **Reset mid-operation:** all queued events are lost, no ack is issued, and pending sources are re-arbitrated from `rr_ptr`=0 after reset release.
- **`SRC_CNT`=1:** degenerates to a plain FIFO with ack.

## Configuration
- **Macro:** `USER_EVENT_ARB_NEWGAME_FLUSH_EN`.
- **With the macro defined,** accepting an `EV_NEW_GAME` event flushes the FIFO:
  - All entries are discarded except any head popped in the same cycle. That head is delivered normally.
  - The FIFO then holds exactly {`EV_NEW_GAME`}, with occupancy=1.
  - `EV_NEW_GAME` is acceptable even when the FIFO is full.
  - `drop_flush_cnt_o` adds the number of discarded entries, saturating at 255.
- **Without the macro,** `EV_NEW_GAME` is queued like any event, there is no flush, and `drop_flush_cnt_o`=0.

## Test plan
- **Basic path:** reset, then src0 presents `EV_LEFT` for one cycle.
  - Required: `src_ack_o`=01 in that cycle, ready=1 next cycle with `user_event_o`=`EV_LEFT`.
  - Pop → ready=0, occupancy=0.
- **Round-robin fairness:** src0 and src1 both continuously valid (`EV_DOWN` / `EV_ROTATE`), no pops.
  - Required: acks alternate 01, 10, 01, 10 until occupancy=4, then acks stay 0.
- **Full with simultaneous pop:** FIFO full, src1 valid with `EV_RIGHT`, rd_req=1 in the same cycle.
  - Required: ack=10, occupancy stays 4, `EV_RIGHT` is last out.
- **Pointer wrap:** push and pop 10 events (alternating `EV_LEFT`/`EV_RIGHT`) through depth 4 with random pop gaps.
  - Required: output sequence identical to input, occupancy never exceeds 4.
- **Flush (macro on):** FIFO holds 3 × `EV_DOWN`, src0 presents `EV_NEW_GAME`.
  - Required: ack in the same cycle, next cycle occupancy=1 with head `EV_NEW_GAME`, `drop_flush_cnt_o`=3.
  - With the macro off: occupancy=4 and `EV_NEW_GAME` is last.
- **Async reset mid-burst:** FIFO holding 2 entries, rst asserted.
  - Required: ready=0, occupancy=0, acks=0 immediately.
  - After release, a pending src1 is granted first (`rr_ptr`=0 scan finds src1 when src0 is idle).
